launchpad_key_scan_rx: RTL

- Receive side of the 8-column pad scan. The mod-8 scan counter drives one column per clock; this block samples the returned row lines for that column.
- Debounces every key of the 8 x ROWS grid and maintains a stable key map.
- Emits press/release events through a small valid/ready event queue to the sound/LED control logic.

---
 rtl/launchpad_key_scan_rx_pkg.sv | 25 ++
 rtl/launchpad_event_fifo.sv | 67 ++++++
 rtl/launchpad_key_scan_rx.sv | 132 +++++++++++++
 3 files changed

// File: rtl/launchpad_key_scan_rx_pkg.sv
// Shared types for the launchpad key-scan receive path: scan geometry and the
// key event record carried through the event queue.
package launchpad_key_scan_rx_pkg;

  localparam int unsigned SCAN_COLS = 8;
  localparam int unsigned COL_W     = 3;
  localparam int unsigned ROW_MAX_W = 3;
  localparam int unsigned CNT_W     = 3;

  // Row field is sized for the largest grid; narrower grids zero the top bits.
  typedef struct packed {
    logic                 press;
    logic [COL_W-1:0]     col;
    logic [ROW_MAX_W-1:0] row;
  } key_event_t;

  function automatic int unsigned row_w(input int unsigned rows);
    return (rows > 1) ? $clog2(rows) : 1;
  endfunction

  function automatic int unsigned event_w();
    return $bits(key_event_t);
  endfunction

endpackage

// File: rtl/launchpad_event_fifo.sv
// Small FIFO with a registered head: valid/ready pop, push dropped when full
// at cycle start (a same-cycle pop does not make room).
module launchpad_event_fifo #(
  parameter int unsigned WIDTH = 7,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             ready,
  output logic             valid,
  output logic [WIDTH-1:0] head,
  output logic             full
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr, rd_ptr, wr_ptr_n, rd_ptr_n;
  logic [CW-1:0]    count, count_n;
  logic             push_ok, pop_ok;
  logic [WIDTH-1:0] head_n;

  // Next head is either the entry being written this cycle or a stored one.
  always_comb begin
    push_ok  = push && (count != CW'(DEPTH));
    pop_ok   = valid && ready;
    wr_ptr_n = push_ok ? wr_ptr + PW'(1) : wr_ptr;
    rd_ptr_n = pop_ok ? rd_ptr + PW'(1) : rd_ptr;
    count_n  = count + CW'(push_ok) - CW'(pop_ok);
    head_n   = head;
    if (count_n != '0) begin
      if (push_ok && (rd_ptr_n == wr_ptr)) begin
        head_n = push_data;
      end else begin
        head_n = mem[rd_ptr_n];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      valid  <= 1'b0;
      full   <= 1'b0;
      head   <= '0;
    end else begin
      wr_ptr <= wr_ptr_n;
      rd_ptr <= rd_ptr_n;
      count  <= count_n;
      valid  <= (count_n != '0);
      full   <= (count_n == CW'(DEPTH));
      head   <= head_n;
    end
  end

endmodule

// File: rtl/launchpad_key_scan_rx.sv
// Launchpad key-scan receiver: synchronises returned rows, debounces every key
// of the 8 x ROWS grid and queues press/release events.
module launchpad_key_scan_rx
  import launchpad_key_scan_rx_pkg::*;
#(
  parameter int unsigned ROWS     = 4,
  parameter int unsigned DEBOUNCE = 3,
  parameter int unsigned QDEPTH   = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [COL_W-1:0]            scan_idx,
  input  logic [ROWS-1:0]             row_in,
  output logic                        ev_valid,
  input  logic                        ev_ready,
  output logic                        ev_press,
  output logic [COL_W-1:0]            ev_col,
  output logic [row_w(ROWS)-1:0]      ev_row,
  output logic [SCAN_COLS*ROWS-1:0]   key_map,
  output logic                        q_full
);

  localparam int unsigned RW   = row_w(ROWS);
  localparam int unsigned KEYS = SCAN_COLS * ROWS;
  localparam int unsigned KW   = $clog2(KEYS);

  logic [ROWS-1:0]              row_s1, row_s2;
  logic [COL_W-1:0]             idx_d1, idx_d2;
  logic [1:0]                   warm;
  logic                         eval_en;
  logic [KEYS-1:0][CNT_W-1:0]   cnt;
  logic [ROWS-1:0][CNT_W-1:0]   cnt_upd;
  logic [ROWS-1:0][KW-1:0]      key_idx;
  logic [ROWS-1:0]              cand;
  logic [KW-1:0]                base;
  logic                         win;
  logic [RW-1:0]                win_row;
  logic                         win_press;
  key_event_t                   push_ev;
  key_event_t                   head_ev;

  // Two-flop row sync; the column index is delayed in step so pairs stay aligned.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      row_s1 <= '0;
      row_s2 <= '0;
      idx_d1 <= '0;
      idx_d2 <= '0;
      warm   <= '0;
    end else begin
      row_s1 <= row_in;
      row_s2 <= row_s1;
      idx_d1 <= scan_idx;
      idx_d2 <= idx_d1;
      warm   <= {warm[0], 1'b1};
    end
  end

  assign eval_en = warm[1];

  // Debounce update for the sampled column, then lowest-row candidate wins.
  always_comb begin
    cand      = '0;
    cnt_upd   = '0;
    key_idx   = '0;
    win       = 1'b0;
    win_row   = '0;
    win_press = 1'b0;
    base      = KW'(int'(idx_d2) * int'(ROWS));
    for (int r = 0; r < int'(ROWS); r++) begin
      key_idx[r] = base + KW'(r);
      if (row_s2[r] != key_map[key_idx[r]]) begin
        if (cnt[key_idx[r]] >= CNT_W'(DEBOUNCE)) begin
          cnt_upd[r] = CNT_W'(DEBOUNCE);
        end else begin
          cnt_upd[r] = cnt[key_idx[r]] + CNT_W'(1);
        end
        cand[r] = (cnt_upd[r] == CNT_W'(DEBOUNCE));
      end
    end
    for (int r = int'(ROWS) - 1; r >= 0; r--) begin
      if (cand[r] && eval_en && !q_full) begin
        win       = 1'b1;
        win_row   = RW'(r);
        win_press = row_s2[r];
      end
    end
  end

  always_comb begin
    push_ev       = '0;
    push_ev.press = win_press;
    push_ev.col   = idx_d2;
    push_ev.row   = ROW_MAX_W'(win_row);
  end

  // Losing or blocked candidates keep a saturated counter and retry next visit.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      key_map <= '0;
      cnt     <= '0;
    end else if (eval_en) begin
      for (int r = 0; r < int'(ROWS); r++) begin
        if (win && (win_row == RW'(r))) begin
          cnt[key_idx[r]]     <= '0;
          key_map[key_idx[r]] <= ~key_map[key_idx[r]];
        end else begin
          cnt[key_idx[r]] <= cnt_upd[r];
        end
      end
    end
  end

  launchpad_event_fifo #(
    .WIDTH (event_w()),
    .DEPTH (QDEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst),
    .push      (win),
    .push_data (push_ev),
    .ready     (ev_ready),
    .valid     (ev_valid),
    .head      (head_ev),
    .full      (q_full)
  );

  assign ev_press = head_ev.press;
  assign ev_col   = head_ev.col;
  assign ev_row   = RW'(head_ev.row);

endmodule
